logic_vector_checker: RTL and testbench

Self-checking stimulus stage that sits directly upstream of a pair of combinational logic implementations under comparison, such as a structural and a behavioural model of the same function. It sweeps every input vector from 0 to 2^N_IN−1 and waits a programmable settle time for each one. It then compares the two implementations' outputs, counts mismatches, and captures the first failing vector. A single `start` pulse runs the complete exhaustive check; `done`/`pass` report the result.

---
 rtl/logic_vector_checker.sv | 109 ++++++++++
 tb/tb_logic_vector_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_vector_checker.sv
// Exhaustive stimulus/compare stage: sweeps every N_IN-bit vector into two
// combinational implementations, waits SETTLE cycles, and tallies disagreements.
module logic_vector_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            q_a,
  input  logic            q_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            err_valid,
  output logic [N_IN-1:0] err_vec,
  output logic [N_IN-1:0] first_err_vec,
  output logic [N_IN:0]   err_count,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = $clog2(SETTLE) + 1;
  localparam int ERR_W = N_IN + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic             launch;
  logic             mismatch;
  logic             last_vec;

  // Case inequality so an X or Z from either implementation is a failure.
  assign mismatch = (q_a !== q_b);
  assign last_vec = &vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_SETTLE;
          launch     = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = last_vec ? S_DONE : S_SETTLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec           <= '0;
      settle_cnt    <= '0;
      err_valid     <= 1'b0;
      err_vec       <= '0;
      first_err_vec <= '0;
      err_count     <= '0;
    end else begin
      err_valid <= 1'b0;
      if (launch) begin
        vec           <= '0;
        settle_cnt    <= CNT_LOAD;
        err_vec       <= '0;
        first_err_vec <= '0;
        err_count     <= '0;
      end else if (state == S_SETTLE) begin
        if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
      end else if (state == S_CHECK) begin
        if (mismatch) begin
          err_count <= err_count + ERR_W'(1);
          err_vec   <= vec;
          err_valid <= 1'b1;
          if (err_count == '0) first_err_vec <= vec;
        end
        // The final vector is held rather than wrapping back to zero.
        if (!last_vec) begin
          vec        <= vec + N_IN'(1);
          settle_cnt <= CNT_LOAD;
        end
      end
    end
  end

  assign busy      = (state == S_SETTLE) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign pass      = (state == S_DONE) && (err_count == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_logic_vector_checker.sv
// Directed bench: one checker with SETTLE=1 (three implementation pairings,
// reset and restart cases) and one with SETTLE=3 (hold time, ignored start).
module tb_logic_vector_checker;

  logic clk;
  logic rst_n;

  // SETTLE=1 instance
  logic       start;
  logic [2:0] vec;
  logic       q_a, q_b;
  logic       busy, done, pass, err_valid;
  logic [2:0] err_vec, first_err_vec;
  logic [3:0] err_count;
  logic [1:0] dbg_state;
  int         mode;

  // SETTLE=3 instance
  logic       start2;
  logic [2:0] vec2;
  logic       q_a2, q_b2;
  logic       busy2, done2, pass2, err_valid2;
  logic [2:0] err_vec2, first_err_vec2;
  logic [3:0] err_count2;
  logic [1:0] dbg_state2;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  logic_vector_checker #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec), .q_a(q_a), .q_b(q_b),
    .busy(busy), .done(done), .pass(pass), .err_valid(err_valid),
    .err_vec(err_vec), .first_err_vec(first_err_vec), .err_count(err_count),
    .dbg_state(dbg_state)
  );

  logic_vector_checker #(.N_IN(3), .SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec(vec2), .q_a(q_a2), .q_b(q_b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_valid(err_valid2),
    .err_vec(err_vec2), .first_err_vec(first_err_vec2), .err_count(err_count2),
    .dbg_state(dbg_state2)
  );

  // Implementation pair: f = a&b | c with vec = {a,b,c}
  always_comb begin
    q_a = (vec[2] & vec[1]) | vec[0];
    case (mode)
      1:       q_b = ~q_a;
      2:       q_b = q_a ^ (vec == 3'b101);
      default: q_b = q_a;
    endcase
    q_a2 = (vec2[2] & vec2[1]) | vec2[0];
    q_b2 = (vec2[2] & vec2[1]) | vec2[0];
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns with time at #1 after the edge that sampled start (edge 0).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one sweep on the SETTLE=1 instance; err_valid pulses are scored
  // against exp_q as they appear.
  task automatic sweep(output int n_done, output int pulses, output int pulse_n);
    int n;
    n       = 0;
    pulses  = 0;
    pulse_n = -1;
    pulse_start();
    check("busy_after_start", busy, 1'b1);
    check("cleared_at_start", err_count, 4'd0);
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (err_valid) begin
        pulses++;
        pulse_n = n;
        if (exp_q.size() > 0) check("err_vec_stream", err_vec, exp_q.pop_front());
      end
    end
    n_done = n;
    check("busy_at_done", busy, 1'b0);
  endtask

  initial begin
    int n_done, pulses, pulse_n, hold_bad, n;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    mode   = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", vec, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identical implementations
    mode = 0;
    sweep(n_done, pulses, pulse_n);
    check("m0_done_edge", n_done, 16);
    check("m0_pass", pass, 1'b1);
    check("m0_err_count", err_count, 4'd0);
    check("m0_pulses", pulses, 0);

    // Inverted B: every vector fails
    mode = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    sweep(n_done, pulses, pulse_n);
    check("m1_done_edge", n_done, 16);
    check("m1_err_count", err_count, 4'd8);
    check("m1_first_err", first_err_vec, 3'd0);
    check("m1_last_err", err_vec, 3'd7);
    check("m1_pulses", pulses, 8);
    check("m1_pass", pass, 1'b0);
    check("m1_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("m1_done_hold", done, 1'b1);
    check("m1_count_hold", err_count, 4'd8);

    // Restart from DONE with identical implementations
    mode = 0;
    sweep(n_done, pulses, pulse_n);
    check("rs_pass", pass, 1'b1);
    check("rs_err_count", err_count, 4'd0);
    check("rs_first_err", first_err_vec, 3'd0);

    // Single fault at vector 5: CHECK after edge 11, pulse visible after edge 12
    mode = 2;
    exp_q.push_back(3'd5);
    sweep(n_done, pulses, pulse_n);
    check("m2_err_count", err_count, 4'd1);
    check("m2_first_err", first_err_vec, 3'd5);
    check("m2_err_vec", err_vec, 3'd5);
    check("m2_pulses", pulses, 1);
    check("m2_pulse_edge", pulse_n, 12);
    check("m2_pass", pass, 1'b0);

    // SETTLE=3: each vector held 4 cycles, start at edge 10 ignored
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2   = 1'b0;
    n        = 0;
    hold_bad = 0;
    check("s3_busy", busy2, 1'b1);
    while (!done2 && n < 400) begin
      if (vec2 != 3'(n / 4)) hold_bad++;
      start2 = (n == 9);
      @(posedge clk);
      #1;
      n++;
    end
    start2 = 1'b0;
    check("s3_vec_hold", hold_bad, 0);
    check("s3_done_edge", n, 32);
    check("s3_pass", pass2, 1'b1);
    check("s3_err_count", err_count2, 4'd0);
    check("s3_vec_final", vec2, 3'd7);

    // Asynchronous reset mid-sweep
    mode = 1;
    pulse_start();
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_count", err_count, 4'd3);
    rst_n = 1'b0;
    #1;
    check("arst_vec", vec, 3'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_err_valid", err_valid, 1'b0);
    check("arst_err_vec", err_vec, 3'd0);
    check("arst_first_err", first_err_vec, 3'd0);
    check("arst_err_count", err_count, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_stays_idle", done, 1'b0);
    mode = 0;
    sweep(n_done, pulses, pulse_n);
    check("post_rst_done_edge", n_done, 16);
    check("post_rst_pass", pass, 1'b1);
    check("post_rst_err_count", err_count, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
